// File: rtl/proj_cloud_to_pixel_pkg.sv
// Shared widths, FSM state type and rounding helper for the cloud-to-pixel projection stage.
package proj_cloud_to_pixel_pkg;

    localparam int CLOUD_BW  = 32;
    localparam int MUL       = 12;
    localparam int FX_BW     = 24;
    localparam int H_SIZE_BW = 10;
    localparam int V_SIZE_BW = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_POST,
        ST_OUT
    } proj_state_t;

    localparam logic signed [FX_BW+1:0] HALF_LSB = (FX_BW+2)'(1 << (MUL - 1));

    // Round half-up from MUL fractional bits to an integer pixel index.
    function automatic logic signed [FX_BW+1:0] round_half_up(input logic signed [FX_BW+1:0] s);
        return (s + HALF_LSB) >>> MUL;
    endfunction

endpackage

// File: rtl/proj_div_serial.sv
// Unsigned serial restoring divider: one quotient bit per cycle, MSB first.
// The caller guarantees dividend < divisor << Q_W, so Q_W quotient bits are exact.
module proj_div_serial #(
    parameter int DVD_W = 57,
    parameter int DVS_W = 31,
    parameter int Q_W   = 24
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DVS_W-1:0] i_divisor,
    output logic [Q_W-1:0]   o_quotient,
    output logic             o_done
);
    localparam int CNT_W = $clog2(Q_W);

    logic [DVD_W-1:0] r_rem;
    logic [DVD_W-1:0] r_dvs;
    logic [Q_W-1:0]   r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             w_ge;

    assign w_ge       = (r_rem >= r_dvs);
    assign o_quotient = r_q;
    // High during the cycle that resolves the last quotient bit.
    assign o_done     = r_busy && (r_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rem  <= '0;
            r_dvs  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= i_dividend;
            r_dvs  <= DVD_W'(i_divisor) << (Q_W - 1);
            r_q    <= '0;
            r_cnt  <= CNT_W'(Q_W - 1);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (w_ge) begin
                r_rem <= r_rem - r_dvs;
            end
            r_q   <= {r_q[Q_W-2:0], w_ge};
            r_dvs <= r_dvs >> 1;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/proj_cloud_to_pixel.sv
// Projects one camera-frame point to rounded pixel coordinates with an in-image flag.
// valid/ready: a transfer happens on a rising edge where valid and ready are both high; the sender holds data until then.
module proj_cloud_to_pixel
    import proj_cloud_to_pixel_pkg::*;
#(
    parameter int DIV_QBW = 24,
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [CLOUD_BW-1:0]  i_cloud_x,
    input  logic [CLOUD_BW-1:0]  i_cloud_y,
    input  logic [CLOUD_BW-1:0]  i_cloud_z,
    input  logic [FX_BW-1:0]     i_fx,
    input  logic [FX_BW-1:0]     i_fy,
    input  logic [FX_BW-1:0]     i_cx,
    input  logic [FX_BW-1:0]     i_cy,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [H_SIZE_BW-1:0] o_u,
    output logic [V_SIZE_BW-1:0] o_v,
    output logic                 o_in_img,
    output logic [2:0]           o_dbg_state
);
    localparam int PW = FX_BW + CLOUD_BW + 1;
    localparam int SW = FX_BW + 2;

    proj_state_t                r_state;
    logic signed [CLOUD_BW-1:0] r_x, r_y, r_z;
    logic [FX_BW-1:0]           r_fx, r_fy, r_cx, r_cy;
    logic                       r_neg_x, r_neg_y, r_bad;
    logic                       r_valid, r_in_img;
    logic [H_SIZE_BW-1:0]       r_u;
    logic [V_SIZE_BW-1:0]       r_v;

    logic signed [PW-1:0]  w_nx, w_ny;
    logic [PW-1:0]         w_abs_nx, w_abs_ny, w_zlim;
    logic                  w_z_pos, w_bad, w_start, w_done_x, w_done_y;
    logic [DIV_QBW-1:0]    w_qx, w_qy;
    logic signed [SW-1:0]  w_qx_s, w_qy_s, w_sx, w_sy, w_su, w_sv, w_ru, w_rv;
    logic                  w_u_ok, w_v_ok, w_in;

    assign w_nx     = PW'($signed({1'b0, r_fx})) * PW'(r_x);
    assign w_ny     = PW'($signed({1'b0, r_fy})) * PW'(r_y);
    assign w_abs_nx = w_nx[PW-1] ? -w_nx : w_nx;
    assign w_abs_ny = w_ny[PW-1] ? -w_ny : w_ny;
    // Any magnitude at or above z<<DIV_QBW would not fit in the quotient register.
    assign w_zlim   = PW'(r_z[CLOUD_BW-2:0]) << DIV_QBW;
    assign w_z_pos  = !r_z[CLOUD_BW-1] && (r_z != '0);
    assign w_bad    = !w_z_pos || (w_abs_nx >= w_zlim) || (w_abs_ny >= w_zlim);
    assign w_start  = (r_state == ST_MUL) && !w_bad;

    proj_div_serial #(.DVD_W(PW), .DVS_W(CLOUD_BW-1), .Q_W(DIV_QBW)) u_div_x (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(w_start), .i_dividend(w_abs_nx),
        .i_divisor(r_z[CLOUD_BW-2:0]), .o_quotient(w_qx), .o_done(w_done_x)
    );

    proj_div_serial #(.DVD_W(PW), .DVS_W(CLOUD_BW-1), .Q_W(DIV_QBW)) u_div_y (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(w_start), .i_dividend(w_abs_ny),
        .i_divisor(r_z[CLOUD_BW-2:0]), .o_quotient(w_qy), .o_done(w_done_y)
    );

    assign w_qx_s = SW'(w_qx);
    assign w_qy_s = SW'(w_qy);
    assign w_sx   = r_neg_x ? -w_qx_s : w_qx_s;
    assign w_sy   = r_neg_y ? -w_qy_s : w_qy_s;
    assign w_su   = w_sx + $signed(SW'(r_cx));
    assign w_sv   = w_sy + $signed(SW'(r_cy));
    assign w_ru   = round_half_up(w_su);
    assign w_rv   = round_half_up(w_sv);
    assign w_u_ok = !w_ru[SW-1] && ($unsigned(w_ru) < SW'(IMG_W));
    assign w_v_ok = !w_rv[SW-1] && ($unsigned(w_rv) < SW'(IMG_H));
    assign w_in   = !r_bad && w_u_ok && w_v_ok;

    assign o_ready     = (r_state == ST_IDLE);
    assign o_valid     = r_valid;
    assign o_u         = r_u;
    assign o_v         = r_v;
    assign o_in_img    = r_in_img;
    assign o_dbg_state = r_state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_z      <= '0;
            r_fx     <= '0;
            r_fy     <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
            r_neg_x  <= 1'b0;
            r_neg_y  <= 1'b0;
            r_bad    <= 1'b0;
            r_valid  <= 1'b0;
            r_in_img <= 1'b0;
            r_u      <= '0;
            r_v      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_x     <= i_cloud_x;
                        r_y     <= i_cloud_y;
                        r_z     <= i_cloud_z;
                        r_fx    <= i_fx;
                        r_fy    <= i_fy;
                        r_cx    <= i_cx;
                        r_cy    <= i_cy;
                        r_state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    r_neg_x <= w_nx[PW-1];
                    r_neg_y <= w_ny[PW-1];
                    r_bad   <= w_bad;
                    r_state <= w_bad ? ST_POST : ST_DIV;
                end
                ST_DIV: begin
                    if (w_done_x && w_done_y) begin
                        r_state <= ST_POST;
                    end
                end
                ST_POST: begin
                    r_in_img <= w_in;
                    r_u      <= w_in ? w_ru[H_SIZE_BW-1:0] : '0;
                    r_v      <= w_in ? w_rv[V_SIZE_BW-1:0] : '0;
                    r_valid  <= 1'b1;
                    r_state  <= ST_OUT;
                end
                ST_OUT: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_proj_cloud_to_pixel.sv
// Self-checking bench for proj_cloud_to_pixel: scoreboard of expected pixels and latencies.
module tb_proj_cloud_to_pixel;
    import proj_cloud_to_pixel_pkg::*;

    localparam int DIV_QBW = 24;
    localparam int IMG_W   = 640;
    localparam int IMG_H   = 480;
    localparam int ONE     = 1 << MUL;
    localparam int TIMEOUT = 200;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 i_valid = 1'b0;
    logic                 o_ready;
    logic [CLOUD_BW-1:0]  i_cloud_x = '0, i_cloud_y = '0, i_cloud_z = '0;
    logic [FX_BW-1:0]     i_fx = '0, i_fy = '0, i_cx = '0, i_cy = '0;
    logic                 o_valid;
    logic                 i_ready = 1'b1;
    logic [H_SIZE_BW-1:0] o_u;
    logic [V_SIZE_BW-1:0] o_v;
    logic                 o_in_img;
    logic [2:0]           o_dbg_state;

    int n_checks = 0;
    int n_fails  = 0;

    logic [19:0] exp_q[$];
    int          exp_lat_q[$];

    proj_cloud_to_pixel #(.DIV_QBW(DIV_QBW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_cloud_x(i_cloud_x), .i_cloud_y(i_cloud_y), .i_cloud_z(i_cloud_z),
        .i_fx(i_fx), .i_fy(i_fy), .i_cx(i_cx), .i_cy(i_cy),
        .o_valid(o_valid), .i_ready(i_ready), .o_u(o_u), .o_v(o_v),
        .o_in_img(o_in_img), .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [19:0] model(input int x, input int y, input int z, input int fx,
                                          input int fy, input int cx, input int cy, output int lat);
        logic signed [95:0] nx, ny, ax, ay, lim, qx, qy, ru, rv;
        bit bad;
        bad = (z <= 0);
        nx  = 96'(fx) * 96'(x);
        ny  = 96'(fy) * 96'(y);
        ax  = (nx < 0) ? -nx : nx;
        ay  = (ny < 0) ? -ny : ny;
        lim = 96'(z) <<< DIV_QBW;
        if (!bad && (ax >= lim || ay >= lim)) bad = 1'b1;
        lat = bad ? 3 : DIV_QBW + 3;
        if (bad) return 20'd0;
        qx = ax / 96'(z);
        qy = ay / 96'(z);
        ru = (((nx < 0) ? -qx : qx) + 96'(cx) + 96'(ONE / 2)) >>> MUL;
        rv = (((ny < 0) ? -qy : qy) + 96'(cy) + 96'(ONE / 2)) >>> MUL;
        if (ru >= 0 && ru < IMG_W && rv >= 0 && rv < IMG_H) return {1'b1, ru[9:0], rv[8:0]};
        return 20'd0;
    endfunction

    // ---------------- driver tasks ----------------
    // Starts and ends at a negedge; pushes expected result; accept edge is the posedge inside.
    task automatic drive_point(input int x, input int y, input int z, input int fx,
                               input int fy, input int cx, input int cy);
        int lat;
        int waited = 0;
        while (!o_ready && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (!o_ready) begin
            n_fails++;
            $display("FAIL drive_ready: o_ready=%0b required 1 after %0d cycles", o_ready, waited);
        end
        i_cloud_x = x; i_cloud_y = y; i_cloud_z = z;
        i_fx = fx[FX_BW-1:0]; i_fy = fy[FX_BW-1:0]; i_cx = cx[FX_BW-1:0]; i_cy = cy[FX_BW-1:0];
        i_valid = 1'b1;
        exp_q.push_back(model(x, y, z, fx, fy, cx, cy, lat));
        exp_lat_q.push_back(lat);
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        // Intrinsics change while busy; only the latched values may be used.
        i_fx = FX_BW'($urandom); i_fy = FX_BW'($urandom);
        i_cx = FX_BW'($urandom); i_cy = FX_BW'($urandom);
    endtask

    task automatic wait_result(output logic [19:0] got, output int lat);
        int cycles = 0;
        while (!o_valid && cycles < TIMEOUT) begin
            @(negedge clk);
            cycles++;
        end
        lat = o_valid ? cycles + 1 : -1;
        got = {o_in_img, o_u, o_v};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %0b required 0", o_valid); end
        n_checks++;
        if ({o_in_img, o_u, o_v} !== 20'd0) begin
            n_fails++; $display("FAIL reset_outputs: got in=%0b u=%0d v=%0d required 0", o_in_img, o_u, o_v);
        end
        n_checks++;
        if (o_ready !== 1'b1 || o_dbg_state !== 3'(ST_IDLE)) begin
            n_fails++; $display("FAIL reset_idle: ready=%0b state=%0d required 1/IDLE", o_ready, o_dbg_state);
        end
    endtask

    // Runs one point with i_ready=1 and checks result, latency and handshake release.
    task automatic run_one(input string name, input int x, input int y, input int z, input int fx,
                           input int fy, input int cx, input int cy);
        logic [19:0] got, exp;
        int lat, exp_lat;
        drive_point(x, y, z, fx, fy, cx, cy);
        wait_result(got, lat);
        exp = exp_q.pop_front();
        exp_lat = exp_lat_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s_result: got in=%0b u=%0d v=%0d required in=%0b u=%0d v=%0d",
                     name, got[19], got[18:9], got[8:0], exp[19], exp[18:9], exp[8:0]);
        end
        n_checks++;
        if (lat !== exp_lat) begin
            n_fails++; $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
        end
        @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_fails++; $display("FAIL %s_release: valid=%0b ready=%0b required 0/1", name, o_valid, o_ready);
        end
    endtask

    task automatic test_nominal();
        run_one("nominal", ONE / 2, -ONE / 4, 2 * ONE, 500 * ONE, 500 * ONE, 320 * ONE, 240 * ONE);
        // Independent of the model: the hand-worked case-1 answer.
        drive_point(ONE / 2, -ONE / 4, 2 * ONE, 500 * ONE, 500 * ONE, 320 * ONE, 240 * ONE);
        begin
            logic [19:0] got;
            int lat;
            wait_result(got, lat);
            void'(exp_q.pop_front());
            void'(exp_lat_q.pop_front());
            n_checks++;
            if (got !== {1'b1, 10'd445, 9'd178}) begin
                n_fails++; $display("FAIL nominal_const: got u=%0d v=%0d in=%0b required 445/178/1",
                                    got[18:9], got[8:0], got[19]);
            end
            n_checks++;
            if (lat !== DIV_QBW + 3) begin
                n_fails++; $display("FAIL nominal_const_latency: got %0d required %0d", lat, DIV_QBW + 3);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bad_z();
        run_one("z_zero", ONE / 2, -ONE / 4, 0, 500 * ONE, 500 * ONE, 320 * ONE, 240 * ONE);
        run_one("z_neg", ONE / 2, -ONE / 4, -ONE, 500 * ONE, 500 * ONE, 320 * ONE, 240 * ONE);
    endtask

    task automatic test_range();
        run_one("u_neg", -ONE, 0, ONE, 500 * ONE, 500 * ONE, 320 * ONE, 240 * ONE);
        run_one("u_round_out", 2620, 0, ONE, 500 * ONE, 500 * ONE, 320 * ONE, 240 * ONE);
        run_one("u_edge_in", 2612, 0, ONE, 500 * ONE, 500 * ONE, 320 * ONE, 240 * ONE);
        run_one("v_edge_out", 0, 1966, ONE, 500 * ONE, 500 * ONE, 320 * ONE, 240 * ONE);
    endtask

    task automatic test_overflow();
        run_one("overflow", 32'h7FFF_FFFF, 0, 1, 500 * ONE, 500 * ONE, 320 * ONE, 240 * ONE);
    endtask

    task automatic test_backpressure();
        logic [19:0] got, exp;
        int lat;
        i_ready = 1'b0;
        drive_point(ONE, ONE / 2, 4 * ONE, 400 * ONE, 400 * ONE, 300 * ONE, 200 * ONE);
        wait_result(got, lat);
        exp = exp_q.pop_front();
        void'(exp_lat_q.pop_front());
        n_checks++;
        if (got !== exp) begin
            n_fails++; $display("FAIL bp_result: got %h required %h", got, exp);
        end
        for (int i = 0; i < 10; i++) begin
            i_valid = (i % 2 == 0);
            i_cloud_x = $urandom; i_cloud_z = ONE;
            @(negedge clk);
            n_checks++;
            if (o_valid !== 1'b1 || {o_in_img, o_u, o_v} !== exp || o_ready !== 1'b0) begin
                n_fails++;
                $display("FAIL bp_hold_%0d: valid=%0b out=%h ready=%0b required 1/%h/0",
                         i, o_valid, {o_in_img, o_u, o_v}, o_ready, exp);
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b0) begin n_fails++; $display("FAIL bp_drop: valid=%0b required 0", o_valid); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_fails++; $display("FAIL bp_no_extra: ready=%0b valid=%0b required 1/0", o_ready, o_valid);
        end
    endtask

    task automatic test_reset_mid_div();
        drive_point(ONE / 2, -ONE / 4, 2 * ONE, 500 * ONE, 500 * ONE, 320 * ONE, 240 * ONE);
        repeat (5) @(negedge clk);
        n_checks++;
        if (o_dbg_state !== 3'(ST_DIV)) begin
            n_fails++; $display("FAIL rst_in_div: state=%0d required %0d", o_dbg_state, ST_DIV);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_lat_q.delete();
        n_checks++;
        if (o_dbg_state !== 3'(ST_IDLE) || o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_fails++; $display("FAIL rst_mid_div: state=%0d valid=%0b ready=%0b required IDLE/0/1",
                                o_dbg_state, o_valid, o_ready);
        end
        repeat (DIV_QBW + 4) @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b0) begin n_fails++; $display("FAIL rst_discard: valid=%0b required 0", o_valid); end
        run_one("after_rst", ONE / 2, -ONE / 4, 2 * ONE, 500 * ONE, 500 * ONE, 320 * ONE, 240 * ONE);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            int z, x, y, fx, fy, cx, cy;
            z  = $urandom_range(16384, ONE);
            x  = int'($urandom_range(2 * z, 0)) - z;
            y  = int'($urandom_range(z, 0)) - z / 2;
            fx = $urandom_range(600 * ONE, 300 * ONE);
            fy = $urandom_range(600 * ONE, 300 * ONE);
            cx = $urandom_range(340 * ONE, 300 * ONE);
            cy = $urandom_range(260 * ONE, 220 * ONE);
            run_one($sformatf("b2b%0d", i), x, y, z, fx, fy, cx, cy);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_nominal();
        test_bad_z();
        test_range();
        test_overflow();
        test_backpressure();
        test_reset_mid_div();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
